// File: rtl/as2650_bus_if.sv
// rtl/as2650_bus_if.sv - AS2650 external bus between the CPU core and a bus target
interface as2650_bus_if;
  logic [12:0] adr;
  logic [7:0]  cpu_dout;
  logic        m_io;
  logic        d_c;
  logic        rw;
  logic        opreq;
  logic        opack_n;
  logic [7:0]  rdata;
  logic        rdata_oe;

  modport master (
    output adr, cpu_dout, m_io, d_c, rw, opreq,
    input  opack_n, rdata, rdata_oe
  );

  modport slave (
    input  adr, cpu_dout, m_io, d_c, rw, opreq,
    output opack_n, rdata, rdata_oe
  );
endinterface

// File: rtl/as2650_bus_target.sv
// rtl/as2650_bus_target.sv - AS2650 bus responder: wait-stated RAM window, I/O ports, optional timer
// Optional interval timer on extended ports 0x02/0x03 enabled by AS2650_TGT_TIMER_EN.
module as2650_bus_target #(
  parameter logic [12:0] MEM_BASE    = 13'h1C00,
  parameter int          MEM_AW      = 6,
  parameter int          WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  as2650_bus_if.slave      bus,
  input  logic [7:0]       port_in,
  output logic [7:0]       port_out,
  output logic             intr_n
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam logic [3:0] WS      = WAIT_STATES[3:0];

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic [7:0] adr_q;
  logic       rw_q, m_io_q, d_c_q;
  logic       opack_q, rdata_oe_q;
  logic [7:0] rdata_q;
  logic [7:0] sync1, sync2;
  logic [7:0] mem [0:(1 << MEM_AW) - 1];
  logic [7:0] timer_reload;
  logic       timer_pending;

  logic       hit;
  logic [7:0] op_adr;
  logic       op_rw, op_m_io, op_d_c;
  logic       enter_ack;
  logic       wr_en, wr_mem, wr_port_out;
  logic [7:0] rd_val;

  assign hit = (bus.m_io && (bus.adr[12:MEM_AW] == MEM_BASE[12:MEM_AW])) || !bus.m_io;

  // With zero wait states ACK is entered straight from IDLE, so use the live bus fields there.
  assign op_adr  = (state == ST_IDLE) ? bus.adr[7:0] : adr_q;
  assign op_rw   = (state == ST_IDLE) ? bus.rw       : rw_q;
  assign op_m_io = (state == ST_IDLE) ? bus.m_io     : m_io_q;
  assign op_d_c  = (state == ST_IDLE) ? bus.d_c      : d_c_q;

  assign enter_ack = ((state == ST_IDLE) && bus.opreq && hit && (WS == 4'd0)) ||
                     ((state == ST_WAIT) && bus.opreq && (wait_cnt == 4'd1));

  assign wr_en       = enter_ack && op_rw;
  assign wr_mem      = wr_en && op_m_io;
  assign wr_port_out = wr_en && !op_m_io && (op_d_c || (op_adr == 8'h00));

  always_comb begin
    rd_val = 8'h00;
    if (op_m_io) begin
      rd_val = mem[op_adr[MEM_AW-1:0]];
    end else if (op_d_c) begin
      rd_val = sync2;
    end else begin
      case (op_adr)
        8'h00:   rd_val = port_out;
        8'h01:   rd_val = sync2;
        8'h02:   rd_val = timer_reload;
        8'h03:   rd_val = {7'b0, timer_pending};
        default: rd_val = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_mem) begin
      mem[op_adr[MEM_AW-1:0]] <= bus.cpu_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      adr_q      <= 8'h00;
      rw_q       <= 1'b0;
      m_io_q     <= 1'b0;
      d_c_q      <= 1'b0;
      opack_q    <= 1'b1;
      rdata_q    <= 8'h00;
      rdata_oe_q <= 1'b0;
      port_out   <= 8'h00;
    end else begin
      if (enter_ack && !op_rw) begin
        rdata_q    <= rd_val;
        rdata_oe_q <= 1'b1;
      end
      if (wr_port_out) begin
        port_out <= bus.cpu_dout;
      end
      case (state)
        ST_IDLE: begin
          if (bus.opreq) begin
            if (hit) begin
              adr_q  <= bus.adr[7:0];
              rw_q   <= bus.rw;
              m_io_q <= bus.m_io;
              d_c_q  <= bus.d_c;
              if (WS == 4'd0) begin
                state <= ST_ACK;
              end else begin
                wait_cnt <= WS;
                state    <= ST_WAIT;
              end
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.opreq) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd1) begin
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (bus.opreq) begin
            opack_q <= 1'b0;
          end else begin
            opack_q    <= 1'b1;
            rdata_oe_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          if (!bus.opreq) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.opack_n  = opack_q;
  assign bus.rdata    = rdata_q;
  assign bus.rdata_oe = rdata_oe_q;

`ifdef AS2650_TGT_TIMER_EN
  logic [7:0] tmr_cnt;
  logic       wr_reload, wr_status, tmr_set;

  assign wr_reload = wr_en && !op_m_io && !op_d_c && (op_adr == 8'h02);
  assign wr_status = wr_en && !op_m_io && !op_d_c && (op_adr == 8'h03);
  assign tmr_set   = !wr_reload && (timer_reload != 8'h00) && (tmr_cnt == 8'h01);

  // The counter rests at zero for one clock before reloading, giving a period of reload+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reload  <= 8'h00;
      tmr_cnt       <= 8'h00;
      timer_pending <= 1'b0;
    end else begin
      if (wr_reload) begin
        timer_reload <= bus.cpu_dout;
        tmr_cnt      <= bus.cpu_dout;
      end else if (timer_reload != 8'h00) begin
        tmr_cnt <= (tmr_cnt == 8'h00) ? timer_reload : tmr_cnt - 8'h01;
      end
      if (tmr_set) begin
        timer_pending <= 1'b1;
      end else if (wr_status) begin
        timer_pending <= 1'b0;
      end
    end
  end

  assign intr_n = ~timer_pending;
`else
  assign timer_reload  = 8'h00;
  assign timer_pending = 1'b0;
  assign intr_n        = 1'b1;
`endif
endmodule

// File: tb/tb_as2650_bus_target.sv
// tb/tb_as2650_bus_target.sv - self-checking bench for as2650_bus_target
module tb_as2650_bus_target;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [12:0] adr;
  logic [7:0]  cpu_dout;
  logic        m_io, d_c, rw, req, sel4;
  logic [7:0]  port_in;
  wire  [7:0]  port_out, port_out4;
  wire         intr_n, intr_n4;

  as2650_bus_if bus ();
  as2650_bus_if bus4 ();

  assign bus.adr       = adr;
  assign bus.cpu_dout  = cpu_dout;
  assign bus.m_io      = m_io;
  assign bus.d_c       = d_c;
  assign bus.rw        = rw;
  assign bus.opreq     = req & ~sel4;
  assign bus4.adr      = adr;
  assign bus4.cpu_dout = cpu_dout;
  assign bus4.m_io     = m_io;
  assign bus4.d_c      = d_c;
  assign bus4.rw       = rw;
  assign bus4.opreq    = req & sel4;

  as2650_bus_target #(.MEM_BASE(13'h1C00), .MEM_AW(6), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .port_in(port_in), .port_out(port_out), .intr_n(intr_n)
  );
  as2650_bus_target #(.MEM_BASE(13'h1C00), .MEM_AW(6), .WAIT_STATES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .port_in(port_in), .port_out(port_out4), .intr_n(intr_n4)
  );

  wire       cur_ack_n = sel4 ? bus4.opack_n  : bus.opack_n;
  wire [7:0] cur_rdata = sel4 ? bus4.rdata    : bus.rdata;
  wire       cur_oe    = sel4 ? bus4.rdata_oe : bus.rdata_oe;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Raises opreq mid-cycle, counts rising edges until opack_n is seen low (lat=1 is the sampling edge).
  task automatic do_op(input logic mi, input logic dc, input logic w, input logic [12:0] a,
                       input logic [7:0] d, input int budget, output logic acked, output int lat,
                       output logic [7:0] rd, output logic oe, output logic irq_n);
    acked = 1'b0; lat = 0; rd = 8'h00; oe = 1'b0; irq_n = 1'b1;
    @(negedge clk);
    m_io = mi; d_c = dc; rw = w; adr = a; cpu_dout = d; req = 1'b1;
    while (!acked && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if (cur_ack_n === 1'b0) begin
        acked = 1'b1; rd = cur_rdata; oe = cur_oe; irq_n = intr_n;
      end
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    if (acked) check("ack_release", {cur_ack_n, cur_oe}, 2'b10);
    repeat (2) @(posedge clk);
  endtask

  typedef struct packed {
    logic        mi, dc, w;
    logic [12:0] a;
    logic [7:0]  d, pin;
    logic        ack;
    logic [7:0]  rd, pout;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] ram_m [64];
  logic [7:0] pout_m;
  logic       acked, oe, irq, exp_ack;
  int         lat;
  logic [7:0] rd, exp_rd;

`ifdef AS2650_TGT_TIMER_EN
  int   cyc = 0;
  logic intr_prev = 1'b1;
  int   falls[$];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (intr_prev && !intr_n) falls.push_back(cyc);
    intr_prev = intr_n;
  end
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel4 = 1'b0; req = 1'b1; m_io = 1'b1; d_c = 1'b0; rw = 1'b1;
    adr = 13'h1C00; cpu_dout = 8'h5C; port_in = 8'h5A;
    repeat (4) begin
      @(posedge clk); #1;
      check("reset_outputs", {bus.opack_n, bus.rdata_oe, bus.rdata, port_out, intr_n},
            {1'b1, 1'b0, 8'h00, 8'h00, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    while (bus.opack_n !== 1'b0 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("reset_release_latency", lat, 3);
    @(negedge clk); req = 1'b0;
    repeat (3) @(posedge clk);
    ram_m[0] = 8'h5C;

    vt.push_back('{1'b1, 1'b0, 1'b1, 13'h1C05, 8'hA5, 8'h5A, 1'b1, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b0, 13'h1C05, 8'h00, 8'h5A, 1'b1, 8'hA5, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b0, 13'h0100, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b1, 13'h1C3F, 8'h96, 8'h5A, 1'b1, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b1, 13'h1BFF, 8'h12, 8'h5A, 1'b0, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b1, 13'h1C40, 8'h34, 8'h5A, 1'b0, 8'h00, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b0, 13'h1C3F, 8'h00, 8'h5A, 1'b1, 8'h96, 8'h00});
    vt.push_back('{1'b1, 1'b0, 1'b0, 13'h1C00, 8'h00, 8'h5A, 1'b1, 8'h5C, 8'h00});
    vt.push_back('{1'b0, 1'b0, 1'b1, 13'h0000, 8'h3C, 8'h5A, 1'b1, 8'h00, 8'h3C});
    vt.push_back('{1'b0, 1'b1, 1'b0, 13'h0123, 8'h00, 8'h5A, 1'b1, 8'h5A, 8'h3C});
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h0000, 8'h00, 8'h5A, 1'b1, 8'h3C, 8'h3C});
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h0001, 8'h00, 8'hA7, 1'b1, 8'hA7, 8'h3C});
    vt.push_back('{1'b0, 1'b0, 1'b1, 13'h0009, 8'hFF, 8'hA7, 1'b1, 8'h00, 8'h3C});
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h0009, 8'h00, 8'hA7, 1'b1, 8'h00, 8'h3C});
    vt.push_back('{1'b0, 1'b1, 1'b1, 13'h0ABC, 8'h77, 8'hA7, 1'b1, 8'h00, 8'h77});
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h1F00, 8'h00, 8'hA7, 1'b1, 8'h77, 8'h77});
`ifndef AS2650_TGT_TIMER_EN
    vt.push_back('{1'b0, 1'b0, 1'b1, 13'h0002, 8'h55, 8'hA7, 1'b1, 8'h00, 8'h77});
    vt.push_back('{1'b0, 1'b0, 1'b1, 13'h0003, 8'h01, 8'hA7, 1'b1, 8'h00, 8'h77});
`endif
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h0002, 8'h00, 8'hA7, 1'b1, 8'h00, 8'h77});
    vt.push_back('{1'b0, 1'b0, 1'b0, 13'h0003, 8'h00, 8'hA7, 1'b1, 8'h00, 8'h77});

    foreach (vt[i]) begin
      port_in = vt[i].pin;
      repeat (3) @(posedge clk);
      do_op(vt[i].mi, vt[i].dc, vt[i].w, vt[i].a, vt[i].d, 20, acked, lat, rd, oe, irq);
      check($sformatf("vec%0d_ack", i), acked, vt[i].ack);
      if (vt[i].ack) check($sformatf("vec%0d_latency", i), lat, 3);
      if (vt[i].ack && !vt[i].w) check($sformatf("vec%0d_rdata", i), {oe, rd}, {1'b1, vt[i].rd});
      check($sformatf("vec%0d_port_out", i), port_out, vt[i].pout);
      check($sformatf("vec%0d_intr_n", i), intr_n, 1'b1);
    end
    pout_m = 8'h77;

    // Four wait states: full write, aborted overwrite, then read back the original byte.
    sel4 = 1'b1;
    do_op(1'b1, 1'b0, 1'b1, 13'h1C10, 8'h11, 20, acked, lat, rd, oe, irq);
    check("ws4_write_latency", {acked, lat[7:0]}, {1'b1, 8'd6});
    @(negedge clk);
    m_io = 1'b1; d_c = 1'b0; rw = 1'b1; adr = 13'h1C10; cpu_dout = 8'hEE; req = 1'b1;
    acked = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus4.opack_n !== 1'b1) acked = 1'b1;
    end
    @(negedge clk); req = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus4.opack_n !== 1'b1) acked = 1'b1;
    end
    check("ws4_abort_no_ack", acked, 1'b0);
    do_op(1'b1, 1'b0, 1'b0, 13'h1C10, 8'h00, 20, acked, lat, rd, oe, irq);
    check("ws4_abort_ram_kept", {acked, lat[7:0], oe, rd}, {1'b1, 8'd6, 1'b1, 8'h11});
    check("ws4_port_out", port_out4, 8'h00);
    check("ws4_intr_n", intr_n4, 1'b1);
    sel4 = 1'b0;

    // Randomized traffic against a behavioural model; RAM is prefilled so every read is defined.
    for (int i = 0; i < 64; i++) begin
      ram_m[i] = 8'($urandom);
      do_op(1'b1, 1'b0, 1'b1, 13'h1C00 + 13'(i), ram_m[i], 20, acked, lat, rd, oe, irq);
      check("prefill_ack", acked, 1'b1);
    end
    for (int i = 0; i < 120; i++) begin
      logic        mi, dc, w;
      logic [12:0] a;
      logic [7:0]  d;
      int          kind;
      kind = int'($urandom_range(0, 3));
      w = 1'($urandom); d = 8'($urandom); dc = 1'b0; mi = 1'b1;
      a = 13'($urandom);
      case (kind)
        0: a = 13'h1C00 + 13'($urandom_range(0, 63));
        1: a = 13'($urandom);
        2: begin
          mi = 1'b0;
`ifdef AS2650_TGT_TIMER_EN
          a[7:0] = 8'($urandom_range(0, 1) + 4 * $urandom_range(0, 1));
`else
          a[7:0] = 8'($urandom_range(0, 5));
`endif
        end
        default: begin mi = 1'b0; dc = 1'b1; end
      endcase
      port_in = 8'($urandom);
      repeat (3) @(posedge clk);
      exp_ack = !mi || (a >= 13'h1C00 && a < 13'h1C40);
      exp_rd = 8'h00;
      if (mi) exp_rd = ram_m[a - 13'h1C00];
      else if (dc || a[7:0] == 8'h01) exp_rd = port_in;
      else if (a[7:0] == 8'h00) exp_rd = pout_m;
      do_op(mi, dc, w, a, d, exp_ack ? 20 : 8, acked, lat, rd, oe, irq);
      check("rand_ack", acked, exp_ack);
      if (exp_ack && !w) check("rand_rdata", {oe, rd}, {1'b1, exp_rd});
      if (exp_ack && w) begin
        if (mi) ram_m[a - 13'h1C00] = d;
        else if (dc || a[7:0] == 8'h00) pout_m = d;
      end
      check("rand_port_out", port_out, pout_m);
    end

`ifdef AS2650_TGT_TIMER_EN
    do_op(1'b0, 1'b0, 1'b1, 13'h0002, 8'h04, 20, acked, lat, rd, oe, irq);
    check("tmr_reload_ack", acked, 1'b1);
    lat = 0;
    while (falls.size() < 1 && lat < 30) begin @(posedge clk); #2; lat++; end
    check("tmr_first_fall", falls.size(), 1);
    do_op(1'b0, 1'b0, 1'b1, 13'h0003, 8'h00, 20, acked, lat, rd, oe, irq);
    check("tmr_clear_intr", irq, 1'b1);
    lat = 0;
    while (falls.size() < 2 && lat < 30) begin @(posedge clk); #2; lat++; end
    check("tmr_period", (falls.size() >= 2) ? falls[1] - falls[0] : -1, 5);
    do_op(1'b0, 1'b0, 1'b0, 13'h0003, 8'h00, 20, acked, lat, rd, oe, irq);
    check("tmr_status_read", {oe, rd}, {1'b1, 8'h01});
    do_op(1'b0, 1'b0, 1'b0, 13'h0002, 8'h00, 20, acked, lat, rd, oe, irq);
    check("tmr_reload_read", {oe, rd}, {1'b1, 8'h04});
    do_op(1'b0, 1'b0, 1'b1, 13'h0003, 8'h00, 20, acked, lat, rd, oe, irq);
    lat = 0;
    while (falls.size() < 3 && lat < 30) begin @(posedge clk); #2; lat++; end
    check("tmr_period_phase", (falls.size() >= 3) ? (falls[2] - falls[1]) % 5 : -1, 0);
    do_op(1'b0, 1'b0, 1'b1, 13'h0002, 8'h00, 20, acked, lat, rd, oe, irq);
    do_op(1'b0, 1'b0, 1'b1, 13'h0003, 8'h00, 20, acked, lat, rd, oe, irq);
    repeat (20) @(posedge clk);
    #1;
    check("tmr_stopped", {intr_n, 8'(falls.size())}, {1'b1, 8'd3});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
